// File: rtl/cpu_run_sequencer.sv
// Run-control sequencer for the toy CPU: loads code memory from a host word
// stream, holds the CPU in reset during load/arm, and gates PC advance for
// free-run and single-step execution until a stop condition is seen.
module cpu_run_sequencer #(
    parameter int          ADDR_W     = 6,
    parameter int          DATA_W     = 16,
    parameter int          RST_CYCLES = 2,
    parameter logic [7:0]  HALT_OP    = 8'hFF,
    parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc_current,
    input  logic [7:0]        instr_opcode,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              pc_en,
    output logic [2:0]        state,
    output logic [2:0]        halt_cause,
    output logic [15:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_HALT = 3'd3,
        S_RUN  = 3'd4,
        S_STEP = 3'd5
    } state_t;

    localparam int ARM_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [2:0] CAUSE_NONE = 3'd0;
    localparam logic [2:0] CAUSE_HOST = 3'd1;
    localparam logic [2:0] CAUSE_BP   = 3'd2;
    localparam logic [2:0] CAUSE_OP   = 3'd3;
    localparam logic [2:0] CAUSE_WD   = 3'd4;
    localparam logic [2:0] CAUSE_STEP = 3'd5;

    state_t            cur;
    state_t            nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ARM_W-1:0]  arm_cnt;
    logic              first_cycle;
    logic              cnt_inc;
    logic              cause_wr;
    logic [2:0]        cause_nxt;

    logic op_halt;
    logic wd_hit;
    logic bp_hit;
    logic last_addr;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign op_halt    = (instr_opcode == HALT_OP);
    assign wd_hit     = (cycle_count == MAX_CYCLES);
    // A breakpoint is masked on the first RUN cycle so resuming from it works.
    assign bp_hit     = bp_en && (pc_current == bp_addr) && !first_cycle;
    assign last_addr  = (ptr == {ADDR_W{1'b1}});
    assign state      = cur;
    assign imem_waddr = ptr;
    assign imem_wdata = load_data;

    // Next-state decode plus the combinational strobes (pc_en, imem_we).
    always_comb begin
        nxt       = cur;
        pc_en     = 1'b0;
        imem_we   = 1'b0;
        cnt_inc   = 1'b0;
        cause_wr  = 1'b0;
        cause_nxt = CAUSE_NONE;
        case (cur)
            S_IDLE: begin
                if (load_start) nxt = S_LOAD;
            end
            S_LOAD: begin
                imem_we = load_valid & load_ready;
                if (imem_we && (load_last || last_addr)) nxt = S_ARM;
            end
            S_ARM: begin
                if (arm_cnt == ARM_W'(RST_CYCLES - 1)) nxt = S_HALT;
            end
            S_HALT: begin
                if (step_req)        nxt = S_STEP;
                else if (run_req)    nxt = S_RUN;
                else if (load_start) nxt = S_LOAD;
            end
            S_RUN: begin
                if (halt_req || op_halt || wd_hit || bp_hit) begin
                    nxt      = S_HALT;
                    cause_wr = 1'b1;
                    if (halt_req)     cause_nxt = CAUSE_HOST;
                    else if (op_halt) cause_nxt = CAUSE_OP;
                    else if (wd_hit)  cause_nxt = CAUSE_WD;
                    else              cause_nxt = CAUSE_BP;
                end else begin
                    pc_en   = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            S_STEP: begin
                nxt      = S_HALT;
                cause_wr = 1'b1;
                if (halt_req) begin
                    cause_nxt = CAUSE_HOST;
                end else if (op_halt) begin
                    cause_nxt = CAUSE_OP;
                end else begin
                    pc_en     = 1'b1;
                    cnt_inc   = 1'b1;
                    cause_nxt = CAUSE_STEP;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_IDLE;
        else        cur <= nxt;
    end

    // Load pointer, arm timer, cycle counter, halt cause and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            arm_cnt     <= '0;
            cycle_count <= 16'd0;
            halt_cause  <= CAUSE_NONE;
            first_cycle <= 1'b0;
            cpu_rst     <= 1'b1;
            load_ready  <= 1'b0;
        end else begin
            // Pointer restarts at 0 on every load entry and sticks at the top.
            if (cur != S_LOAD && nxt == S_LOAD)
                ptr <= '0;
            else if (imem_we && !last_addr)
                ptr <= ptr + 1'b1;

            if (cur == S_ARM) arm_cnt <= arm_cnt + 1'b1;
            else              arm_cnt <= '0;

            if (cur == S_ARM)  cycle_count <= 16'd0;
            else if (cnt_inc)  cycle_count <= sat_inc(cycle_count);

            if (cur == S_ARM)
                halt_cause <= CAUSE_NONE;
            else if (cur == S_HALT && (nxt == S_RUN || nxt == S_STEP))
                halt_cause <= CAUSE_NONE;
            else if (cause_wr)
                halt_cause <= cause_nxt;

            first_cycle <= (cur == S_HALT) && (nxt == S_RUN);
            cpu_rst     <= (nxt == S_IDLE) || (nxt == S_LOAD) || (nxt == S_ARM);
            load_ready  <= (nxt == S_LOAD);
        end
    end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed, table-driven bench for cpu_run_sequencer with hand-written
// sequences for long loads, host halt and asynchronous reset.
module tb_cpu_run_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start, load_valid, load_last, load_ready;
    logic [15:0] load_data;
    logic        run_req, step_req, halt_req, bp_en;
    logic [5:0]  bp_addr, pc_current;
    logic [7:0]  instr_opcode;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        cpu_rst, pc_en;
    logic [2:0]  state, halt_cause;
    logic [15:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        ls, lv, ll, rr, sr, hr, bpe;
        logic [15:0] ld;
        logic [5:0]  bpa, pc;
        logic [7:0]  opc;
        logic [2:0]  st;
        logic        crst, rdy, pen, we;
        logic [5:0]  wa;
        logic [2:0]  cause;
        logic [15:0] cc;
    } vec_t;

    vec_t vecs[$];

    cpu_run_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready),
        .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc_current(pc_current),
        .instr_opcode(instr_opcode),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .pc_en(pc_en), .state(state),
        .halt_cause(halt_cause), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input int ls, input int lv, input int ld, input int ll,
                                input int rr, input int sr, input int hr, input int bpe,
                                input int bpa, input int pc, input int opc,
                                input int st, input int crst, input int rdy, input int pen,
                                input int we, input int wa, input int cause, input int cc);
        vec_t v;
        v.ls = ls[0]; v.lv = lv[0]; v.ld = ld[15:0]; v.ll = ll[0];
        v.rr = rr[0]; v.sr = sr[0]; v.hr = hr[0]; v.bpe = bpe[0];
        v.bpa = bpa[5:0]; v.pc = pc[5:0]; v.opc = opc[7:0];
        v.st = st[2:0]; v.crst = crst[0]; v.rdy = rdy[0]; v.pen = pen[0];
        v.we = we[0]; v.wa = wa[5:0]; v.cause = cause[2:0]; v.cc = cc[15:0];
        vecs.push_back(v);
    endfunction

    task automatic idle_inputs();
        load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
        run_req = 0; step_req = 0; halt_req = 0; bp_en = 0;
        bp_addr = 0; pc_current = 0; instr_opcode = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (state != 3'd3 && n < 10) begin
            tick();
            n++;
        end
        #2;
        chk(name, state, 3);
    endtask

    initial begin
        bit seen_pen;
        rst_n = 1'b0;
        idle_inputs();

        //  ls lv ld      ll rr sr hr bpe bpa pc opc   | st crst rdy pen we wa cause cc
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  0, 0,      0, 1,  0,  0,  0, 0, 0, 0);
        add(1, 0, 0,      0, 0, 0, 0, 0,  0,  0, 0,      0, 1,  0,  0,  0, 0, 0, 0);
        add(0, 1, 'h5005, 0, 0, 0, 0, 0,  0,  0, 0,      1, 1,  1,  0,  1, 0, 0, 0);
        add(0, 1, 'h500A, 0, 0, 0, 0, 0,  0,  0, 0,      1, 1,  1,  0,  1, 1, 0, 0);
        add(0, 0, 'h0000, 0, 0, 0, 0, 0,  0,  0, 0,      1, 1,  1,  0,  0, 2, 0, 0);
        add(0, 1, 'h7002, 0, 0, 0, 0, 0,  0,  0, 0,      1, 1,  1,  0,  1, 2, 0, 0);
        add(0, 1, 'hFF00, 1, 0, 0, 0, 0,  0,  0, 0,      1, 1,  1,  0,  1, 3, 0, 0);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  0, 0,      2, 1,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  0, 0,      2, 1,  0,  0,  0, 0, 0, 0);
        // free run to the HALT opcode at PC 3
        add(0, 0, 0,      0, 1, 0, 0, 0,  0,  0, 'h50,   3, 0,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  0, 'h50,   4, 0,  0,  1,  0, 0, 0, 0);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  1, 'h50,   4, 0,  0,  1,  0, 0, 0, 1);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  2, 'h70,   4, 0,  0,  1,  0, 0, 0, 2);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  3, 'hFF,   4, 0,  0,  0,  0, 0, 0, 3);
        add(0, 0, 0,      0, 0, 0, 0, 1,  2,  3, 'hFF,   3, 0,  0,  0,  0, 0, 3, 3);
        // breakpoint at PC 2, then resume past it
        add(0, 0, 0,      0, 1, 0, 0, 1,  2,  0, 'h50,   3, 0,  0,  0,  0, 0, 3, 3);
        add(0, 0, 0,      0, 0, 0, 0, 1,  2,  0, 'h50,   4, 0,  0,  1,  0, 0, 0, 3);
        add(0, 0, 0,      0, 0, 0, 0, 1,  2,  1, 'h50,   4, 0,  0,  1,  0, 0, 0, 4);
        add(0, 0, 0,      0, 0, 0, 0, 1,  2,  2, 'h70,   4, 0,  0,  0,  0, 0, 0, 5);
        add(0, 0, 0,      0, 1, 0, 0, 1,  2,  2, 'h70,   3, 0,  0,  0,  0, 0, 2, 5);
        add(0, 0, 0,      0, 0, 0, 0, 1,  2,  2, 'h70,   4, 0,  0,  1,  0, 0, 0, 5);
        add(0, 0, 0,      0, 0, 0, 0, 1,  2,  3, 'hFF,   4, 0,  0,  0,  0, 0, 0, 6);
        // single steps; breakpoint ignored while stepping at PC 2
        add(0, 0, 0,      0, 0, 1, 0, 0,  0,  0, 'h50,   3, 0,  0,  0,  0, 0, 3, 6);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  0, 'h50,   5, 0,  0,  1,  0, 0, 0, 6);
        add(0, 0, 0,      0, 0, 1, 0, 0,  0,  1, 'h50,   3, 0,  0,  0,  0, 0, 5, 7);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  1, 'h50,   5, 0,  0,  1,  0, 0, 0, 7);
        add(0, 0, 0,      0, 0, 1, 0, 1,  2,  2, 'h70,   3, 0,  0,  0,  0, 0, 5, 8);
        add(0, 0, 0,      0, 0, 0, 0, 1,  2,  2, 'h70,   5, 0,  0,  1,  0, 0, 0, 8);
        // step and run together: step wins, one commit only
        add(0, 0, 0,      0, 1, 1, 0, 0,  0,  3, 'h50,   3, 0,  0,  0,  0, 0, 5, 9);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  3, 'h50,   5, 0,  0,  1,  0, 0, 0, 9);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  3, 'h50,   3, 0,  0,  0,  0, 0, 5, 10);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  3, 'h50,   3, 0,  0,  0,  0, 0, 5, 10);
        // step onto the HALT opcode: no commit, cause 3
        add(0, 0, 0,      0, 0, 1, 0, 0,  0,  3, 'hFF,   3, 0,  0,  0,  0, 0, 5, 10);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  3, 'hFF,   5, 0,  0,  0,  0, 0, 0, 10);
        add(0, 0, 0,      0, 0, 0, 0, 0,  0,  3, 'hFF,   3, 0,  0,  0,  0, 0, 3, 10);

        repeat (2) @(posedge clk);
        #3;
        chk("rst.state", state, 0);
        chk("rst.cpu_rst", cpu_rst, 1);
        chk("rst.load_ready", load_ready, 0);
        chk("rst.cycle_count", cycle_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            load_start = vecs[i].ls; load_valid = vecs[i].lv; load_data = vecs[i].ld;
            load_last = vecs[i].ll; run_req = vecs[i].rr; step_req = vecs[i].sr;
            halt_req = vecs[i].hr; bp_en = vecs[i].bpe; bp_addr = vecs[i].bpa;
            pc_current = vecs[i].pc; instr_opcode = vecs[i].opc;
            #2;
            chk($sformatf("v%0d.state", i), state, vecs[i].st);
            chk($sformatf("v%0d.cpu_rst", i), cpu_rst, vecs[i].crst);
            chk($sformatf("v%0d.load_ready", i), load_ready, vecs[i].rdy);
            chk($sformatf("v%0d.pc_en", i), pc_en, vecs[i].pen);
            chk($sformatf("v%0d.imem_we", i), imem_we, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("v%0d.imem_waddr", i), imem_waddr, vecs[i].wa);
                chk($sformatf("v%0d.imem_wdata", i), imem_wdata, vecs[i].ld);
            end
            chk($sformatf("v%0d.halt_cause", i), halt_cause, vecs[i].cause);
            chk($sformatf("v%0d.cycle_count", i), cycle_count, vecs[i].cc);
            tick();
        end

        // 64-word stream without load_last ends at address 63
        idle_inputs();
        load_start = 1;
        tick();
        load_start = 0;
        for (int i = 0; i < 64; i++) begin
            load_valid = 1;
            load_data  = 16'h1000 + 16'(i);
            #2;
            chk($sformatf("full%0d.we", i), imem_we, 1);
            chk($sformatf("full%0d.waddr", i), imem_waddr, i);
            tick();
        end
        #2;
        chk("full.state_arm", state, 2);
        chk("full.no_65th_write", imem_we, 0);
        load_valid = 0;
        wait_halt("full.arm_to_halt");
        chk("full.cpu_rst_released", cpu_rst, 0);
        chk("full.cycle_count", cycle_count, 0);

        // host halt held across run entry: nothing committed
        seen_pen   = 0;
        halt_req   = 1;
        run_req    = 1;
        pc_current = 0;
        instr_opcode = 8'h50;
        #1;
        if (pc_en) seen_pen = 1;
        tick();
        run_req = 0;
        #2;
        chk("hreq.state_run", state, 4);
        if (pc_en) seen_pen = 1;
        tick();
        #2;
        if (pc_en) seen_pen = 1;
        chk("hreq.state_halt", state, 3);
        chk("hreq.cause", halt_cause, 1);
        chk("hreq.pc_en_seen", int'(seen_pen), 0);
        halt_req = 0;

        // reset in the middle of a load
        load_start = 1;
        tick();
        load_start = 0;
        load_valid = 1;
        load_data  = 16'hAAAA;
        tick();
        tick();
        #1;
        rst_n = 0;
        #1;
        chk("rstload.state", state, 0);
        chk("rstload.cpu_rst", cpu_rst, 1);
        chk("rstload.load_ready", load_ready, 0);
        chk("rstload.imem_we", imem_we, 0);
        tick();
        rst_n = 1;
        load_valid = 0;
        load_start = 1;
        tick();
        load_start = 0;
        load_valid = 1;
        load_last  = 1;
        load_data  = 16'hABCD;
        #2;
        chk("rstload.restart_we", imem_we, 1);
        chk("rstload.restart_addr", imem_waddr, 0);
        tick();
        load_valid = 0;
        load_last  = 0;
        wait_halt("rstrun.arm_to_halt");

        // reset in the middle of a free run
        instr_opcode = 8'h00;
        run_req = 1;
        tick();
        run_req = 0;
        repeat (3) tick();
        #1;
        chk("rstrun.state_run", state, 4);
        chk("rstrun.cc_before", cycle_count, 3);
        rst_n = 0;
        #1;
        chk("rstrun.state", state, 0);
        chk("rstrun.cpu_rst", cpu_rst, 1);
        chk("rstrun.pc_en", pc_en, 0);
        chk("rstrun.cycle_count", cycle_count, 0);
        tick();
        rst_n = 1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
